// File: rtl/hold_repeat_ctrl_if.sv
// Button-to-counter bus for the hold/auto-repeat controller: button levels and
// the tick/enable qualifiers come in, increment strobes and status go out.
interface hold_repeat_ctrl_if;
    logic       tick;
    logic       enable;
    logic       sec_req;
    logic       min_req;
    logic       inc_seconds;
    logic       inc_minutes;
    logic [1:0] grant;
    logic       repeating;
    logic       fast;

    modport master (
        output tick, enable, sec_req, min_req,
        input  inc_seconds, inc_minutes, grant, repeating, fast
    );

    modport slave (
        input  tick, enable, sec_req, min_req,
        output inc_seconds, inc_minutes, grant, repeating, fast
    );
endinterface

// File: rtl/hold_repeat_ctrl.sv
// Hold/auto-repeat controller for the minutes and seconds set buttons.
// A press gives one immediate increment; holding gives repeats after an
// initial delay, then faster repeats once enough repeats have been issued.
// Only one button is served at a time; seconds wins a same-cycle tie.
module hold_repeat_ctrl #(
    parameter int INIT_DELAY_TICKS = 50,
    parameter int REPEAT_TICKS     = 30,
    parameter int FAST_TICKS       = 10,
    parameter int FAST_AFTER       = 8,
    parameter int CNT_W            = 8
) (
    input logic               clk,
    input logic               reset,
    hold_repeat_ctrl_if.slave bus
);

    localparam logic [1:0] WAIT_LOW = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] DELAY    = 2'd2;
    localparam logic [1:0] REPEAT   = 2'd3;

    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_DELAY_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] FAST_C   = CNT_W'(FAST_TICKS);
    localparam logic [CNT_W-1:0] AFTER_C  = CNT_W'(FAST_AFTER);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
    logic [CNT_W-1:0] repCnt_q, repCnt_d;
    logic             incSec_q, incSec_d;
    logic             incMin_q, incMin_d;
    logic             repeating_q, fast_q;

    logic             grantedReq;
    logic             drop;
    logic             strobe;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] tickNext;

    // Next-state logic: a disable or a release of the served button always
    // beats a coinciding period-expiring tick, so no strobe leaks out then.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        tickCnt_d  = tickCnt_q;
        repCnt_d   = repCnt_q;
        strobe     = 1'b0;
        grantedReq = (grant_q[0] & bus.sec_req) | (grant_q[1] & bus.min_req);
        period     = (repCnt_q < AFTER_C) ? REPEAT_C : FAST_C;
        tickNext   = tickCnt_q + ONE_C;
        drop       = !bus.enable ||
                     (((state_q == DELAY) || (state_q == REPEAT)) && !grantedReq);

        if (drop) begin
            state_d   = WAIT_LOW;
            grant_d   = 2'b00;
            tickCnt_d = '0;
            repCnt_d  = '0;
        end else begin
            case (state_q)
                WAIT_LOW: begin
                    if (!bus.sec_req && !bus.min_req) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (bus.sec_req || bus.min_req) begin
                        grant_d   = bus.sec_req ? 2'b01 : 2'b10;
                        strobe    = 1'b1;
                        tickCnt_d = '0;
                        repCnt_d  = '0;
                        state_d   = DELAY;
                    end
                end
                DELAY: begin
                    if (bus.tick) begin
                        if (tickNext == INIT_C) begin
                            strobe    = 1'b1;
                            tickCnt_d = '0;
                            repCnt_d  = ONE_C;
                            state_d   = REPEAT;
                        end else begin
                            tickCnt_d = tickNext;
                        end
                    end
                end
                REPEAT: begin
                    if (bus.tick) begin
                        if (tickNext == period) begin
                            strobe    = 1'b1;
                            tickCnt_d = '0;
                            if (repCnt_q < AFTER_C) begin
                                repCnt_d = repCnt_q + ONE_C;
                            end
                        end else begin
                            tickCnt_d = tickNext;
                        end
                    end
                end
                default: begin
                    state_d = WAIT_LOW;
                    grant_d = 2'b00;
                end
            endcase
        end

        incSec_d = strobe & grant_d[0];
        incMin_d = strobe & grant_d[1];
    end

    // State, counters and registered outputs; reset lands in WAIT_LOW so a
    // button held through reset must be released before it can fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_LOW;
            grant_q     <= 2'b00;
            tickCnt_q   <= '0;
            repCnt_q    <= '0;
            incSec_q    <= 1'b0;
            incMin_q    <= 1'b0;
            repeating_q <= 1'b0;
            fast_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tickCnt_q   <= tickCnt_d;
            repCnt_q    <= repCnt_d;
            incSec_q    <= incSec_d;
            incMin_q    <= incMin_d;
            repeating_q <= (state_d == REPEAT);
            fast_q      <= (repCnt_d == AFTER_C);
        end
    end

    assign bus.inc_seconds = incSec_q;
    assign bus.inc_minutes = incMin_q;
    assign bus.grant       = grant_q;
    assign bus.repeating   = repeating_q;
    assign bus.fast        = fast_q;

endmodule

// File: tb/tb_hold_repeat_ctrl.sv
// Directed bench for hold_repeat_ctrl with shortened timing
// (delay 5 ticks, slow period 3, fast period 1, fast after 2 repeats).
module tb_hold_repeat_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int assertions = 0;
    int failures   = 0;
    int secCount   = 0;
    int minCount   = 0;
    int glitchCount = 0;
    logic prevSec = 1'b0;
    logic prevMin = 1'b0;

    hold_repeat_ctrl_if bus ();

    hold_repeat_ctrl #(
        .INIT_DELAY_TICKS(5),
        .REPEAT_TICKS    (3),
        .FAST_TICKS      (1),
        .FAST_AFTER      (2),
        .CNT_W           (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and records over-wide or overlapping strobes
    always @(negedge clk) begin
        if (bus.inc_seconds && bus.inc_minutes) glitchCount = glitchCount + 1;
        if (bus.inc_seconds && prevSec) glitchCount = glitchCount + 1;
        if (bus.inc_minutes && prevMin) glitchCount = glitchCount + 1;
        prevSec = bus.inc_seconds;
        prevMin = bus.inc_minutes;
        if (bus.inc_seconds) secCount = secCount + 1;
        if (bus.inc_minutes) minCount = minCount + 1;
    end

    task automatic idleClocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseTick();
        bus.tick = 1'b1;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        bus.tick = 1'b0;
        bus.enable = 1'b1;
        bus.sec_req = 1'b1;
        bus.min_req = 1'b0;
        reset = 1'b1;
        idleClocks(3);
        assertions++;
        if ({bus.inc_seconds, bus.inc_minutes, bus.grant, bus.repeating, bus.fast} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000",
                     {bus.inc_seconds, bus.inc_minutes, bus.grant, bus.repeating, bus.fast});
        end
        reset = 1'b0;
        idleClocks(3);
        assertions++;
        if (secCount !== 0 || bus.grant !== 2'b00) begin
            failures++;
            $display("[TB] FAIL held_through_reset: strobes %0d grant %b expected 0 and 00",
                     secCount, bus.grant);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
    endtask

    task automatic test_hold_sequence();
        int minBase;
        logic expInc;
        minBase = minCount;
        bus.sec_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.inc_seconds !== 1'b1 || bus.grant !== 2'b01 || bus.repeating !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_press: inc %b grant %b rep %b expected 1 01 0",
                     bus.inc_seconds, bus.grant, bus.repeating);
        end
        idleClocks(3);
        for (int t = 1; t <= 11; t++) begin
            pulseTick();
            expInc = (t == 5) || (t >= 8);
            assertions++;
            if (bus.inc_seconds !== expInc || bus.inc_minutes !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_strobe tick %0d: inc_s %b inc_m %b expected %b 0",
                         t, bus.inc_seconds, bus.inc_minutes, expInc);
            end
            assertions++;
            if (bus.repeating !== (t >= 5) || bus.fast !== (t >= 8)) begin
                failures++;
                $display("[TB] FAIL hold_status tick %0d: rep %b fast %b expected %b %b",
                         t, bus.repeating, bus.fast, (t >= 5), (t >= 8));
            end
            idleClocks(3);
        end
        bus.sec_req = 1'b0;
        idleClocks(1);
        assertions++;
        if (bus.grant !== 2'b00 || bus.repeating !== 1'b0 || bus.fast !== 1'b0 ||
            minCount !== minBase) begin
            failures++;
            $display("[TB] FAIL hold_release: grant %b rep %b fast %b min strobes %0d expected 00 0 0 0",
                     bus.grant, bus.repeating, bus.fast, minCount - minBase);
        end
        idleClocks(1);
    endtask

    task automatic test_simultaneous();
        int minBase;
        bus.sec_req = 1'b1;
        bus.min_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.grant !== 2'b01 || bus.inc_seconds !== 1'b1 || bus.inc_minutes !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_break: grant %b inc_s %b inc_m %b expected 01 1 0",
                     bus.grant, bus.inc_seconds, bus.inc_minutes);
        end
        idleClocks(3);
        bus.sec_req = 1'b0;
        idleClocks(1);
        minBase = minCount;
        assertions++;
        if (bus.grant !== 2'b00) begin
            failures++;
            $display("[TB] FAIL tie_release: grant %b expected 00", bus.grant);
        end
        for (int t = 0; t < 3; t++) begin
            pulseTick();
            idleClocks(3);
        end
        assertions++;
        if (minCount !== minBase || bus.grant !== 2'b00) begin
            failures++;
            $display("[TB] FAIL other_held: min strobes %0d grant %b expected 0 00",
                     minCount - minBase, bus.grant);
        end
        bus.min_req = 1'b0;
        idleClocks(2);
        bus.min_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.inc_minutes !== 1'b1 || bus.grant !== 2'b10) begin
            failures++;
            $display("[TB] FAIL repress_min: inc_m %b grant %b expected 1 10",
                     bus.inc_minutes, bus.grant);
        end
        bus.min_req = 1'b0;
        idleClocks(2);
    endtask

    task automatic test_tap();
        int minBase;
        minBase = minCount;
        bus.min_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.grant !== 2'b10) begin
            failures++;
            $display("[TB] FAIL tap_grant: grant %b expected 10", bus.grant);
        end
        idleClocks(3);
        pulseTick();
        idleClocks(3);
        pulseTick();
        idleClocks(3);
        bus.min_req = 1'b0;
        idleClocks(1);
        assertions++;
        if (bus.grant !== 2'b00 || (minCount - minBase) !== 1) begin
            failures++;
            $display("[TB] FAIL tap_release: grant %b strobes %0d expected 00 1",
                     bus.grant, minCount - minBase);
        end
        idleClocks(1);
        bus.min_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.inc_minutes !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tap_back_to_idle: inc_m %b expected 1", bus.inc_minutes);
        end
        bus.min_req = 1'b0;
        idleClocks(2);
    endtask

    task automatic test_enable_drop();
        int secBase;
        bus.sec_req = 1'b1;
        idleClocks(4);
        for (int t = 1; t <= 7; t++) begin
            pulseTick();
            idleClocks(3);
        end
        secBase = secCount;
        bus.tick = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        assertions++;
        if (bus.inc_seconds !== 1'b0 || bus.grant !== 2'b00 || bus.repeating !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_drop: inc_s %b grant %b rep %b expected 0 00 0",
                     bus.inc_seconds, bus.grant, bus.repeating);
        end
        idleClocks(3);
        bus.enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            pulseTick();
            idleClocks(3);
        end
        assertions++;
        if (secCount !== secBase || bus.grant !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reenable_held: strobes %0d grant %b expected 0 00",
                     secCount - secBase, bus.grant);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
        bus.sec_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.inc_seconds !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reenable_press: inc_s %b expected 1", bus.inc_seconds);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
    endtask

    task automatic test_reset_mid();
        int secBase;
        bus.sec_req = 1'b1;
        idleClocks(4);
        for (int t = 1; t <= 6; t++) begin
            pulseTick();
            idleClocks(3);
        end
        reset = 1'b1;
        idleClocks(1);
        assertions++;
        if ({bus.inc_seconds, bus.inc_minutes, bus.grant, bus.repeating, bus.fast} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got %b expected 000000",
                     {bus.inc_seconds, bus.inc_minutes, bus.grant, bus.repeating, bus.fast});
        end
        reset = 1'b0;
        secBase = secCount;
        for (int t = 0; t < 3; t++) begin
            pulseTick();
            idleClocks(3);
        end
        assertions++;
        if (secCount !== secBase) begin
            failures++;
            $display("[TB] FAIL post_reset_held: strobes %0d expected 0", secCount - secBase);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
        bus.sec_req = 1'b1;
        idleClocks(1);
        assertions++;
        if (bus.inc_seconds !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_press: inc_s %b expected 1", bus.inc_seconds);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
    endtask

    task automatic test_saturation();
        int secBase;
        secBase = secCount;
        bus.sec_req = 1'b1;
        idleClocks(4);
        for (int t = 1; t <= 40; t++) begin
            pulseTick();
            if (t >= 8) begin
                assertions++;
                if (bus.fast !== 1'b1 || bus.inc_seconds !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL saturate tick %0d: fast %b inc_s %b expected 1 1",
                             t, bus.fast, bus.inc_seconds);
                end
            end
            idleClocks(3);
        end
        bus.sec_req = 1'b0;
        idleClocks(2);
        assertions++;
        if ((secCount - secBase) !== 35) begin
            failures++;
            $display("[TB] FAIL saturate_count: strobes %0d expected 35", secCount - secBase);
        end
        assertions++;
        if (glitchCount !== 0) begin
            failures++;
            $display("[TB] FAIL strobe_shape: violations %0d expected 0", glitchCount);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_hold_sequence();
        test_simultaneous();
        test_tap();
        test_enable_drop();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
